// File: rtl/write_back_stage_pkg.sv
// Shared encodings for the write-back stage: write-back source select,
// register-write enable, bubble markers and the stage state enum.
package write_back_stage_pkg;

  // Write-back source select
  localparam logic [3:0] WB_X   = 4'd0;
  localparam logic [3:0] WB_ALU = 4'd1;
  localparam logic [3:0] WB_MEM = 4'd2;
  localparam logic [3:0] WB_PC  = 4'd3;
  localparam logic [3:0] WB_CSR = 4'd4;

  // Register-file write request
  localparam logic REN_X = 1'b0;
  localparam logic REN_S = 1'b1;

  // Bubble markers: a PC of all ones never belongs to a real instruction
  localparam logic [31:0] REGPC_NOP = 32'hFFFF_FFFF;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

  // Stage state: RUN commits every valid bundle, DRAIN waits for the redirect target
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

endpackage

// File: rtl/write_back_stage_counters.sv
// Performance counters for the write-back stage: retired instructions,
// elapsed cycles and memory-stall cycles. All wrap naturally at 2^CNT_W.
module wb_counters #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instret_en,
  input  logic             stall_en,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [CNT_W-1:0] instret_r;
  logic [CNT_W-1:0] cycle_r;
  logic [CNT_W-1:0] stall_r;

  // Counter state: cycle always advances, the others on their enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
      cycle_r   <= '0;
      stall_r   <= '0;
    end else begin
      cycle_r <= cycle_r + CNT_W'(1);
      if (instret_en) begin
        instret_r <= instret_r + CNT_W'(1);
      end
      if (stall_en) begin
        stall_r <= stall_r + CNT_W'(1);
      end
    end
  end

  assign instret      = instret_r;
  assign cycle        = cycle_r;
  assign stall_cycles = stall_r;

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: commits retired bundles to the register file,
// raises the one-cycle branch hazard with the fetch redirect target, and
// drops wrong-path bundles until the redirect target arrives.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  in_read_data,
  input  logic [XLEN-1:0]  in_reg_pc,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_alu_out,
  input  logic             in_br_flg,
  input  logic [XLEN-1:0]  in_br_target,
  input  logic             in_rf_wen,
  input  logic [3:0]       in_wb_sel,
  input  logic [4:0]       in_wb_addr,
  input  logic             in_jmp_flg,
  input  logic [XLEN-1:0]  in_csr_rdata,
  input  logic             in_mem_stall,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             branch_hazard,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [XLEN-1:0] NOP_PC = XLEN'(REGPC_NOP);

  wb_state_e       state_r;
  wb_state_e       state_nxt_s;
  logic [XLEN-1:0] saved_target_r;
  logic [XLEN-1:0] wdata_s;
  logic            valid_s;
  logic            commit_s;
  logic            redirect_s;
  logic            wen_s;
  logic            unused_inst_s;

  // The instruction word is carried for tracing only; nothing here decodes it
  assign unused_inst_s = ^in_inst;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a redirecting commit always (re)enters DRAIN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (redirect_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (redirect_s) begin
          state_nxt_s = DRAIN;
        end else if (commit_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Commit decode: in DRAIN only the saved redirect target may retire
  always_comb begin
    valid_s  = (in_reg_pc != NOP_PC);
    commit_s = 1'b0;
    case (state_r)
      RUN:     commit_s = valid_s;
      DRAIN:   commit_s = valid_s && (in_reg_pc == saved_target_r);
      default: commit_s = 1'b0;
    endcase
    redirect_s = commit_s && (in_br_flg || in_jmp_flg);
    wen_s      = commit_s && (in_rf_wen == REN_S) && (in_wb_addr != 5'd0);
  end

  // Write-back source select; unknown selects write zero
  always_comb begin
    wdata_s = '0;
    case (in_wb_sel)
      WB_ALU:  wdata_s = in_alu_out;
      WB_MEM:  wdata_s = in_read_data;
      WB_PC:   wdata_s = in_reg_pc + XLEN'(32'd4);
      WB_CSR:  wdata_s = in_csr_rdata;
      WB_X:    wdata_s = '0;
      default: wdata_s = '0;
    endcase
  end

  // Registered commit outputs and saved redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we          <= 1'b0;
      rf_waddr       <= 5'd0;
      rf_wdata       <= '0;
      branch_hazard  <= 1'b0;
      redirect_pc    <= '0;
      saved_target_r <= '0;
    end else begin
      rf_we         <= wen_s;
      branch_hazard <= redirect_s;
      if (commit_s) begin
        rf_waddr <= in_wb_addr;
        rf_wdata <= wdata_s;
      end
      if (redirect_s) begin
        redirect_pc    <= in_br_target;
        saved_target_r <= in_br_target;
      end
    end
  end

  wb_counters #(
    .CNT_W (CNT_W)
  ) u_counters (
    .clk          (clk),
    .rst_n        (rst_n),
    .instret_en   (commit_s),
    .stall_en     (in_mem_stall),
    .instret      (instret),
    .cycle        (cycle),
    .stall_cycles (stall_cycles)
  );

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios followed by
// randomized bundles, all checked against a behavioural commit model.
module tb_write_back_stage;
  import write_back_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_read_data, in_reg_pc, in_inst, in_alu_out, in_br_target, in_csr_rdata;
  logic        in_br_flg, in_rf_wen, in_jmp_flg, in_mem_stall;
  logic [3:0]  in_wb_sel;
  logic [4:0]  in_wb_addr;
  logic        rf_we, branch_hazard;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, redirect_pc;
  logic [63:0] instret, cycle, stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit              m_drain;
  logic [31:0]     m_tgt;
  longint unsigned m_instret, m_cycle, m_stall;

  write_back_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_read_data(in_read_data), .in_reg_pc(in_reg_pc), .in_inst(in_inst),
    .in_alu_out(in_alu_out), .in_br_flg(in_br_flg), .in_br_target(in_br_target),
    .in_rf_wen(in_rf_wen), .in_wb_sel(in_wb_sel), .in_wb_addr(in_wb_addr),
    .in_jmp_flg(in_jmp_flg), .in_csr_rdata(in_csr_rdata), .in_mem_stall(in_mem_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .branch_hazard(branch_hazard), .redirect_pc(redirect_pc),
    .instret(instret), .cycle(cycle), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_drain = 1'b0; m_tgt = 32'd0;
    m_instret = 64'd0; m_cycle = 64'd0; m_stall = 64'd0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, ".waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, ".wdata"}, 64'(rf_wdata), 64'd0);
    chk({tag, ".hazard"}, 64'(branch_hazard), 64'd0);
    chk({tag, ".rpc"}, 64'(redirect_pc), 64'd0);
    chk({tag, ".instret"}, instret, 64'd0);
    chk({tag, ".cycle"}, cycle, 64'd0);
    chk({tag, ".stall"}, stall_cycles, 64'd0);
  endtask

  task automatic bubble();
    in_reg_pc = REGPC_NOP; in_inst = INST_NOP;
    in_br_flg = 1'b0; in_jmp_flg = 1'b0; in_rf_wen = REN_X;
    in_wb_sel = WB_X; in_wb_addr = 5'd0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [3:0] sel, input logic wen,
                       input logic [4:0] addr, input logic br, input logic jmp,
                       input logic [31:0] tgt);
    in_reg_pc = pc; in_inst = 32'h0000_0033; in_wb_sel = sel; in_rf_wen = wen;
    in_wb_addr = addr; in_br_flg = br; in_jmp_flg = jmp; in_br_target = tgt;
  endtask

  // One clock: predict from current inputs, advance, then compare
  task automatic tick(input string tag);
    bit          take, e_we, e_haz;
    logic [31:0] e_data, e_rpc;
    take = (in_reg_pc != REGPC_NOP) && (!m_drain || in_reg_pc == m_tgt);
    e_we = take && in_rf_wen && (in_wb_addr != 5'd0);
    if (in_wb_sel == WB_ALU)      e_data = in_alu_out;
    else if (in_wb_sel == WB_MEM) e_data = in_read_data;
    else if (in_wb_sel == WB_PC)  e_data = in_reg_pc + 32'd4;
    else if (in_wb_sel == WB_CSR) e_data = in_csr_rdata;
    else                          e_data = 32'd0;
    e_haz = take && (in_br_flg || in_jmp_flg);
    e_rpc = in_br_target;
    if (take) m_instret++;
    if (in_mem_stall) m_stall++;
    m_cycle++;
    if (e_haz) begin
      m_drain = 1'b1; m_tgt = in_br_target;
    end else if (take) begin
      m_drain = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(e_we));
    if (e_we) begin
      chk({tag, ".waddr"}, 64'(rf_waddr), 64'(in_wb_addr));
      chk({tag, ".wdata"}, 64'(rf_wdata), 64'(e_data));
    end
    chk({tag, ".hazard"}, 64'(branch_hazard), 64'(e_haz));
    if (e_haz) chk({tag, ".rpc"}, 64'(redirect_pc), 64'(e_rpc));
    chk({tag, ".instret"}, instret, m_instret);
    chk({tag, ".cycle"}, cycle, m_cycle);
    chk({tag, ".stall"}, stall_cycles, m_stall);
  endtask

  initial begin
    in_read_data = 32'hDEAD_0001; in_alu_out = 32'd0; in_br_target = 32'd0;
    in_csr_rdata = 32'hC5C5_0002; in_mem_stall = 1'b0;
    bubble();
    model_reset();

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // ALU write
    in_alu_out = 32'h1234;
    drive(32'h100, WB_ALU, REN_S, 5'd5, 1'b0, 1'b0, 32'h0);
    tick("alu");
    chk("alu.instret1", instret, 64'd1);

    // Write to x0 is suppressed but still retires
    in_alu_out = 32'hFFFF;
    drive(32'h104, WB_ALU, REN_S, 5'd0, 1'b0, 1'b0, 32'h0);
    tick("x0");

    // JAL with link write and redirect
    drive(32'h200, WB_PC, REN_S, 5'd1, 1'b0, 1'b1, 32'h400);
    tick("jal");
    chk("jal.wdata204", 64'(rf_wdata), 64'h204);
    bubble(); tick("jal.after");

    // Wrong-path bundles dropped in DRAIN, target commits
    drive(32'h204, WB_ALU, REN_S, 5'd2, 1'b0, 1'b0, 32'h0); tick("drain204");
    drive(32'h208, WB_ALU, REN_S, 5'd3, 1'b1, 1'b0, 32'h900); tick("drain208");
    in_alu_out = 32'hABCD;
    drive(32'h400, WB_ALU, REN_S, 5'd4, 1'b0, 1'b0, 32'h0); tick("drain400");
    drive(32'h404, WB_ALU, REN_S, 5'd6, 1'b0, 1'b0, 32'h0); tick("run404");

    // PC+4 wraps
    drive(32'hFFFF_FFFC, WB_PC, REN_S, 5'd7, 1'b0, 1'b0, 32'h0); tick("wrap");

    // Remaining sources, including an unknown select
    drive(32'h410, WB_MEM, REN_S, 5'd8, 1'b0, 1'b0, 32'h0); tick("mem");
    drive(32'h414, WB_CSR, REN_S, 5'd9, 1'b0, 1'b0, 32'h0); tick("csr");
    drive(32'h418, WB_X, REN_S, 5'd10, 1'b0, 1'b0, 32'h0); tick("wbx");
    drive(32'h41C, 4'd9, REN_S, 5'd11, 1'b0, 1'b0, 32'h0); tick("wbbad");

    // Branch, then a redirecting commit while draining reloads the target
    drive(32'h500, WB_X, REN_X, 5'd0, 1'b1, 1'b0, 32'h600); tick("br500");
    drive(32'h600, WB_X, REN_X, 5'd0, 1'b1, 1'b0, 32'h700); tick("br600");
    drive(32'h604, WB_ALU, REN_S, 5'd12, 1'b0, 1'b0, 32'h0); tick("drop604");
    drive(32'h600, WB_ALU, REN_S, 5'd12, 1'b0, 1'b0, 32'h0); tick("drop600");
    drive(32'h700, WB_ALU, REN_S, 5'd13, 1'b0, 1'b0, 32'h0); tick("hit700");

    // Stall cycles with bubbles
    in_mem_stall = 1'b1; bubble();
    for (int i = 0; i < 3; i++) tick("stall");
    in_mem_stall = 1'b0;

    // Randomized bundles
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)      in_reg_pc = REGPC_NOP;
      else if (r < 5) in_reg_pc = m_drain ? m_tgt : 32'($urandom_range(0, 63)) << 2;
      else if (r < 6) in_reg_pc = 32'hFFFF_FFFC;
      else            in_reg_pc = 32'($urandom_range(0, 63)) << 2;
      in_br_flg    = ($urandom_range(0, 5) == 0);
      in_jmp_flg   = ($urandom_range(0, 7) == 0);
      in_br_target = 32'($urandom_range(0, 63)) << 2;
      in_rf_wen    = 1'($urandom_range(0, 1));
      in_wb_sel    = 4'($urandom_range(0, 5));
      in_wb_addr   = 5'($urandom_range(0, 31));
      in_alu_out   = $urandom;
      in_read_data = $urandom;
      in_csr_rdata = $urandom;
      in_inst      = $urandom;
      in_mem_stall = 1'($urandom_range(0, 1));
      tick("rand");
    end

    // Asynchronous reset while draining clears everything immediately
    in_mem_stall = 1'b0;
    drive(32'h800, WB_PC, REN_S, 5'd1, 1'b0, 1'b1, 32'h900);
    if (m_drain) begin
      in_reg_pc = m_tgt;
    end else begin
      in_reg_pc = 32'h800;
    end
    tick("pre_rst");
    chk("pre_rst.hazard_hi", 64'(branch_hazard), 64'd1);
    bubble();
    #2;
    in_mem_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // Back in RUN: a bundle that is not the lost target commits
    in_alu_out = 32'h5555;
    drive(32'h300, WB_ALU, REN_S, 5'd7, 1'b0, 1'b0, 32'h0);
    tick("post_rst");
    bubble(); tick("post_rst.bubble");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
